max_pool_2x2: RTL

- Streaming 2x2 max-pooling stage directly downstream of the ReLU activation stage.
- Consumes one activation row vector of NUM_UNITS lanes per accepted beat and buffers the even row of each pair.
- On the odd row, emits one pooled row of NUM_UNITS/2 lanes holding the max of each 2x2 window.
- Valid/ready on both sides; a feature-map boundary marker flushes a dangling unpaired row.

---
 rtl/tpu_pkg.sv | 13 +
 rtl/max2.sv | 12 +
 rtl/max_pool_2x2.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types for the TPU datapath stages: default lane type and pooling FSM states.
package tpu_pkg;

    localparam int TPU_DATA_WIDTH = 16;

    typedef logic signed [TPU_DATA_WIDTH-1:0] lane_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pool_state_e;

endpackage

// File: rtl/max2.sv
// Combinational signed two-input maximum; building block for the pooling trees.
module max2 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] max_o
);

    assign max_o = (a_i > b_i) ? a_i : b_i;

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 max-pool: buffers the even row, emits one pooled row per row pair,
// and flushes an unpaired row through a horizontal-only max when in_last arrives.
module max_pool_2x2
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]   in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_UNITS/2-1:0][DATA_WIDTH-1:0] out_data,
    output logic                                   out_last,
    output logic [CNT_WIDTH-1:0]                   out_count
);

    localparam int NUM_OUT = NUM_UNITS / 2;

    generate
        if (NUM_UNITS % 2 != 0) begin : g_odd_units
            $error("max_pool_2x2: NUM_UNITS must be even");
        end
    endgenerate

    pool_state_e                           state_q, state_d;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  row_buf_q, row_buf_d;
    logic                                  out_valid_q, out_valid_d;
    logic [NUM_OUT-1:0][DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                                  out_last_q, out_last_d;
    logic [CNT_WIDTH-1:0]                  count_q, count_d;

    logic [NUM_OUT-1:0][DATA_WIDTH-1:0]    pair_max;
    logic [NUM_OUT-1:0][DATA_WIDTH-1:0]    quad_max;
    logic                                  accept, emit, load;

    // Per output lane: max of the incoming pair, max of the buffered pair, then both combined.
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0] in_max, buf_max, quad;

            max2 #(.DATA_WIDTH(DATA_WIDTH)) u_row_max (
                .a_i   (in_data[2*gi]),
                .b_i   (in_data[2*gi+1]),
                .max_o (in_max)
            );
            max2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf_max (
                .a_i   (row_buf_q[2*gi]),
                .b_i   (row_buf_q[2*gi+1]),
                .max_o (buf_max)
            );
            max2 #(.DATA_WIDTH(DATA_WIDTH)) u_col_max (
                .a_i   (buf_max),
                .b_i   (in_max),
                .max_o (quad)
            );

            assign pair_max[gi] = in_max;
            assign quad_max[gi] = quad;
        end
    endgenerate

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = out_valid_q && out_ready;
    assign load     = accept && ((state_q == HALF) || in_last);

    always_comb begin
        state_d     = state_q;
        row_buf_d   = row_buf_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;

        if (accept) begin
            if (state_q == HALF) begin
                out_data_d = quad_max;
                out_last_d = in_last;
                state_d    = EMPTY;
            end else if (in_last) begin
                out_data_d = pair_max;
                out_last_d = 1'b1;
            end else begin
                row_buf_d = in_data;
                state_d   = HALF;
            end
        end

        // A load wins over an emit so back-to-back beats keep out_valid high.
        if (load) begin
            out_valid_d = 1'b1;
        end else if (emit) begin
            out_valid_d = 1'b0;
        end

        if (emit) begin
            count_d = out_last_q ? '0 : count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            row_buf_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            row_buf_q   <= row_buf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_count = count_q;

endmodule
